pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It generates stall and flush controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It covers three cases: load-use hazards, multi-cycle mult/div occupancy of HI/LO, and interrupt/exception flushes. Its mem_wb_flush output drives the IntBeq input of MEM_WB.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu after issue
DIV_CYCLES, 10, busy cycles for div/divu after issue
CNT_W, 4, width of the mult/div busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
id_rs  in  5  ID-stage rs field
id_rt  in  5  ID-stage rt field
id_use_rs  in  1  ID instruction reads rs in ID/EX
id_use_rt  in  1  ID instruction reads rt in ID/EX
id_md_use  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
ex_WReg  in  5  EX-stage destination register
ex_RegWrite  in  1  EX-stage write enable
ex_MemtoReg  in  3  EX-stage writeback select; 3'd1 = load
ex_md_start  in  1  EX stage issues mult/div this cycle
ex_md_op  in  1  0 = mult, 1 = div
int_req  in  1  CP0 interrupt/exception request, level
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF_ID
flush_if_id  out  1  clear IF_ID
flush_id_ex  out  1  insert bubble into ID_EX
flush_ex_mem  out  1  clear EX_MEM
mem_wb_flush  out  1  to MEM_WB IntBeq
int_ack  out  1  interrupt accepted this cycle; CP0 latches EPC/EXL
md_busy  out  1  mult/div unit occupied

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: while rst=1 all outputs are 0, the state is RUN and the counter is 0. The cycle after rst falls, normal evaluation resumes.
- States:
  - RUN (normal operation).
  - INT_HOLD (single recovery cycle).
- Transitions:
  - RUN -> INT_HOLD when int_req=1.
  - INT_HOLD -> RUN unconditionally after 1 cycle. int_req is ignored in INT_HOLD.
- Interrupt (combinational in RUN with int_req=1):
  - int_ack, flush_if_id, flush_id_ex, flush_ex_mem and mem_wb_flush are all 1.
  - stall_pc and stall_if_id are 0, so the PC loads the handler address.
  - The interrupt has priority over every stall source.
- INT_HOLD: all flush outputs and int_ack are 0. Stall logic is evaluated normally.
- Load-use stall (RUN and INT_HOLD):
  - Condition: ex_RegWrite and ex_MemtoReg==3'd1 and ex_WReg!=0, and the register matches a used source: (id_use_rs and id_rs==ex_WReg) or (id_use_rt and id_rt==ex_WReg).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1.
- Mult/div counter (unsigned, CNT_W bits):
  - On ex_md_start=1, load MULT_CYCLES or DIV_CYCLES according to ex_md_op. Otherwise decrement while nonzero. It saturates at 0 and never wraps.
  - md_busy = (counter != 0).
  - An interrupt does not abort the counter, so the HI/LO result is preserved.
  - ex_md_start while busy reloads the counter (restart). Start takes precedence over decrement.
- Mult/div stall: id_md_use and (md_busy or ex_md_start). Response is identical to the load-use stall. Simultaneous load-use and md stall gives a single stall with the same outputs.
- Latency: all stall and flush outputs are combinational from the current inputs, state and counter. Only the state and the counter are registered.
- Reset mid-operation: the counter is cleared, state returns to RUN, and any pending stall is dropped.

Decomposition:
- Shared package pipe_pkg:
  - MEMTOREG_LOAD = 3'd1
  - MD_OP_MULT = 0, MD_OP_DIV = 1
  - State encoding RUN = 1'b0, INT_HOLD = 1'b1
- Sub-module md_busy_counter: parameters MULT_CYCLES, DIV_CYCLES and CNT_W; inputs clk, rst, start and op; output busy. The hazard comparators and the FSM stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_MemtoReg=1, ex_RegWrite=1, ex_WReg=8, id_rs=8, id_use_rs=1 -> stall_pc=stall_if_id=flush_id_ex=1 that cycle. Same stimulus with ex_WReg=0 -> all 0.
- Mult busy: ex_md_start=1, ex_md_op=0 at cycle 0 -> md_busy=1 for cycles 1..5, 0 at cycle 6. With id_md_use=1 held, stall for cycles 0..5 and release at 6.
- Div restart: start div at cycle 0, then start mult at cycle 3 -> md_busy=1 through cycle 8 and 0 at cycle 9.
- Interrupt priority: load-use condition and int_req=1 together in RUN -> int_ack=1, all four flushes 1, stall_pc=0. Next cycle (INT_HOLD) with int_req still 1 -> int_ack=0, no flushes.
- Interrupt during div: div started at cycle 0, int_req at cycle 2 -> flush at cycle 2, md_busy stays 1 until cycle 10.
- Sync reset: rst=1 at cycle 3 of a div -> counter 0 at the next edge, md_busy=0, all outputs 0 while rst=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback-select
// code for loads, mult/div opcode select and the controller FSM states.
package pipe_pkg;

  localparam logic [2:0] MEMTOREG_LOAD = 3'd1;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic {
    RUN      = 1'b0,
    INT_HOLD = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/md_busy_counter.sv
// Tracks HI/LO occupancy by the multi-cycle mult/div unit; a new start
// always reloads, otherwise the count drains to zero and holds there.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;

  assign w_load = (op == MD_OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= w_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and
// mult/div stalls plus interrupt flushes with a one-cycle recovery state.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_md_use,
  input  logic [4:0] ex_WReg,
  input  logic       ex_RegWrite,
  input  logic [2:0] ex_MemtoReg,
  input  logic       ex_md_start,
  input  logic       ex_md_op,
  input  logic       int_req,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       mem_wb_flush,
  output logic       int_ack,
  output logic       md_busy
);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;

  logic w_cnt_busy;
  logic w_ex_load;
  logic w_load_use;
  logic w_md_stall;
  logic w_stall;
  logic w_take_int;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (ex_md_start),
    .op    (ex_md_op),
    .busy  (w_cnt_busy)
  );

  // A load writing r0 never creates a dependency.
  assign w_ex_load  = ex_RegWrite && (ex_MemtoReg == MEMTOREG_LOAD) && (ex_WReg != 5'd0);
  assign w_load_use = w_ex_load &&
                      ((id_use_rs && (id_rs == ex_WReg)) ||
                       (id_use_rt && (id_rt == ex_WReg)));
  assign w_md_stall = id_md_use && (w_cnt_busy || ex_md_start);
  assign w_stall    = w_load_use || w_md_stall;
  assign w_take_int = (r_state == RUN) && int_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mem_wb_flush = 1'b0;
    int_ack      = 1'b0;
    md_busy      = 1'b0;

    case (r_state)
      RUN:      if (int_req) w_state_nxt = INT_HOLD;
      INT_HOLD: w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase

    // Reset forces every output low, even if the counter has not yet cleared.
    if (!rst) begin
      md_busy = w_cnt_busy;
      if (w_take_int) begin
        int_ack      = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (w_stall) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

endmodule
